// File: rtl/bcd_to_bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Also holds the helper that sizes the largest value the packed BCD input can carry.
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] CORR_THRESH   = 4'd8;
    localparam logic [3:0] CORR_VALUE    = 4'd3;

    // Largest value representable by 'decades' BCD digits (10^decades - 1).
    function automatic longint unsigned bcd_max_value(input int decades);
        longint unsigned acc;
        acc = 1;
        for (int i = 0; i < decades; i++) begin
            acc = acc * 10;
        end
        return acc - 1;
    endfunction

endpackage

// File: rtl/bcd_to_bin_nibble_corr.sv
// Reverse double-dabble correction cell: a nibble that reaches 8 after the
// right shift gets 3 subtracted, undoing the half-weight carry from the next digit.
import bcd_to_bin_pkg::*;

module bcd_nibble_corr (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = nibble;
        if (nibble >= CORR_THRESH) begin
            corrected = nibble - CORR_VALUE;
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one result bit per clock-enabled step, with start/busy/done and digit checking.
import bcd_to_bin_pkg::*;

module bcd_to_bin #(
    parameter int IN_DECADES = 4,
    parameter int OUT_BITS   = 14
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    CE,
    input  logic                    START,
    input  logic [4*IN_DECADES-1:0] IN,
    output logic [OUT_BITS-1:0]     Q,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR
);

    localparam int BCD_W  = 4 * IN_DECADES;
    localparam int SR_W   = BCD_W + OUT_BITS;
    localparam int CNT_W  = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

    generate
        if (bcd_max_value(IN_DECADES) >= (64'd1 << OUT_BITS)) begin : g_width_check
            $error("bcd_to_bin: OUT_BITS too small to hold 10^IN_DECADES - 1");
        end
    endgenerate

    state_t                state_reg, state_next;
    logic [SR_W-1:0]       sr_reg, sr_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [OUT_BITS-1:0]   q_reg, q_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;

    logic [SR_W-1:0]       sr_shift;
    logic [SR_W-1:0]       sr_corr;
    logic [IN_DECADES-1:0] digit_bad;

    assign sr_shift = sr_reg >> 1;
    assign sr_corr[OUT_BITS-1:0] = sr_shift[OUT_BITS-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < IN_DECADES; gi++) begin : g_digit
            bcd_nibble_corr u_corr (
                .nibble    (sr_shift[OUT_BITS + 4*gi +: 4]),
                .corrected (sr_corr[OUT_BITS + 4*gi +: 4])
            );
            assign digit_bad[gi] = (sr_reg[OUT_BITS + 4*gi +: 4] > BCD_DIGIT_MAX);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Pulses default low every edge so DONE/ERR stay one clock wide even with CE low.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (CE) begin
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        sr_next    = {IN, {OUT_BITS{1'b0}}};
                        busy_next  = 1'b1;
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (|digit_bad) begin
                        err_next   = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        cnt_next   = '0;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_next = sr_corr;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = FIN;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                FIN: begin
                    q_next     = sr_reg[OUT_BITS-1:0];
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign Q    = q_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign ERR  = err_reg;

endmodule
